// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with HI/LO, multiply-accumulate and flush.
// Results are computed at issue and held in pending regs until the busy countdown expires.
module mdu_multicycle #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_type,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] md_out
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3, OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI = 4'd5, OP_MFLO  = 4'd6, OP_MTHI = 4'd7, OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD = 4'd9, OP_MADDU = 4'd10, OP_MSUB = 4'd11, OP_MSUBU = 4'd12;

  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic is_mul, is_div, is_sgn, is_acc, is_sub, accept, accept_long, commit;

  always_comb begin
    is_mul = md_type inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    is_div = md_type inside {OP_DIV, OP_DIVU};
    is_sgn = md_type inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    is_acc = md_type inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    is_sub = md_type inside {OP_MSUB, OP_MSUBU};
  end

  assign accept      = start && (state_q == IDLE) && !flush;
  assign accept_long = accept && (is_mul || is_div);
  assign commit      = (state_q == RUN) && !flush && (cnt_q == CW'(1));

  // Multiply: extend to 2*WIDTH so the truncated product is exact for both signednesses.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
  always_comb begin
    ext_a   = is_sgn ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
    ext_b   = is_sgn ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
    prod    = ext_a * ext_b;
    mul_res = prod;
    if (is_acc) mul_res = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
  end

  // Divide on magnitudes then restore signs; MIN/-1 wraps back to MIN with remainder 0.
  logic             neg_a, neg_b, rt_zero;
  logic [WIDTH-1:0] abs_a, abs_b, div_b, uq, ur, quo, rem;
  always_comb begin
    neg_a   = is_sgn && rs[WIDTH-1];
    neg_b   = is_sgn && rt[WIDTH-1];
    rt_zero = (rt == '0);
    abs_a   = neg_a ? -rs : rs;
    abs_b   = neg_b ? -rt : rt;
    div_b   = rt_zero ? WIDTH'(1) : abs_b;
    uq      = abs_a / div_b;
    ur      = abs_a % div_b;
    quo     = (neg_a ^ neg_b) ? -uq : uq;
    rem     = neg_a ? -ur : ur;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_long) state_d = RUN;
      RUN:     if (flush || cnt_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    cnt_d     = cnt_q;
    done_d    = commit;
    if (accept && md_type == OP_MTHI) hi_d = rs;
    if (accept && md_type == OP_MTLO) lo_d = rs;
    if (accept_long) begin
      pend_wr_d = is_mul || !rt_zero;
      cnt_d     = is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
      if (is_mul) {pend_hi_d, pend_lo_d} = mul_res;
      else        {pend_hi_d, pend_lo_d} = {rem, quo};
    end else if (state_q == RUN) begin
      cnt_d = (flush || commit) ? '0 : cnt_q - CW'(1);
    end
    if (commit && pend_wr_q) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    md_out = '0;
    if (md_type == OP_MFHI) md_out = hi_q;
    if (md_type == OP_MFLO) md_out = lo_q;
  end
endmodule

// File: tb/tb_mdu_multicycle.sv
// Directed bench for mdu_multicycle: multiply, divide, accumulate, flush, reset, busy-ignore.
module tb_mdu_multicycle;
  localparam logic [3:0] NONE = 0, MULT = 1, MULTU = 2, DIV = 3, DIVU = 4, MFHI = 5, MFLO = 6;
  localparam logic [3:0] MTHI = 7, MTLO = 8, MADD = 9, MADDU = 10, MSUB = 11, MSUBU = 12;

  logic        clk = 0, reset = 0, start = 0, flush = 0;
  logic [3:0]  md_type = NONE;
  logic [31:0] rs = 0, rt = 0;
  logic        busy, done;
  logic [31:0] md_out;
  int checks = 0, errors = 0;

  mdu_multicycle #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_type(md_type), .rs(rs), .rt(rt),
    .flush(flush), .busy(busy), .done(done), .md_out(md_out));

  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); start = 1; md_type = t; rs = a; rt = b;
    @(negedge clk); start = 0; md_type = NONE;
  endtask

  // Counts busy cycles and done pulses until the unit is idle again (bounded).
  task automatic wait_long(output int bc, output int dc);
    bc = 0; dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (done) dc++;
      if (i > 0 && !busy && !done) break;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    md_type = MFHI; #1 h = md_out;
    md_type = MFLO; #1 l = md_out;
    md_type = NONE; #1;
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (md_out !== 32'h0) begin errors++; $display("FAIL reset_none_out: got %h want 0", md_out); end
    read_hilo(h, l);
    checks++; if ({h, l} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h want 0", {h, l}); end
    @(negedge clk); @(negedge clk); reset = 1;
  endtask

  task automatic test_mult;
    int bc, dc; logic [31:0] h, l;
    issue(MULT, 32'hFFFFFFFE, 32'd3); wait_long(bc, dc);
    checks++; if (bc !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL mult_done_pulses: got %0d want 1", dc); end
    read_hilo(h, l);
    checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFA) begin errors++; $display("FAIL mult_result: got %h want FFFFFFFFFFFFFFFA", {h, l}); end
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_long(bc, dc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_result: got %h want FFFFFFFE00000001", {h, l}); end
  endtask

  task automatic test_div;
    int bc, dc; logic [31:0] h, l;
    issue(DIVU, 32'd100, 32'd7); wait_long(bc, dc); read_hilo(h, l);
    checks++; if (bc !== 10) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 10", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL divu_done_pulses: got %0d want 1", dc); end
    checks++; if ({h, l} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_result: got %h want 000000020000000E", {h, l}); end
    issue(DIV, 32'hFFFFFFF9, 32'd2); wait_long(bc, dc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg_dividend: got %h want FFFFFFFFFFFFFFFD", {h, l}); end
    issue(DIV, 32'd7, 32'hFFFFFFFE); wait_long(bc, dc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL div_neg_divisor: got %h want 00000001FFFFFFFD", {h, l}); end
    issue(DIV, 32'h80000000, 32'hFFFFFFFF); wait_long(bc, dc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_overflow: got %h want 0000000080000000", {h, l}); end
  endtask

  task automatic test_macc;
    int bc, dc; logic [31:0] h, l;
    @(negedge clk); start = 1; md_type = MTHI; rs = 32'h12345678;
    @(negedge clk); md_type = MTLO; rs = 32'd1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
    @(negedge clk); start = 0; md_type = NONE;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_busy_done: got %b%b want 00", busy, done); end
    read_hilo(h, l);
    checks++; if ({h, l} !== 64'h12345678_00000001) begin errors++; $display("FAIL mthi_mtlo: got %h want 1234567800000001", {h, l}); end
    issue(MADDU, 32'd2, 32'd3); wait_long(bc, dc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'h12345678_00000007) begin errors++; $display("FAIL maddu_result: got %h want 1234567800000007", {h, l}); end
    checks++; if (bc !== 5) begin errors++; $display("FAIL maddu_busy_cycles: got %0d want 5", bc); end
    issue(MSUB, 32'd1, 32'd8); wait_long(bc, dc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'h12345677_FFFFFFFF) begin errors++; $display("FAIL msub_result: got %h want 12345677FFFFFFFF", {h, l}); end
    issue(MADD, 32'hFFFFFFFF, 32'd1); wait_long(bc, dc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'h12345677_FFFFFFFE) begin errors++; $display("FAIL madd_signed: got %h want 12345677FFFFFFFE", {h, l}); end
    issue(MSUBU, 32'h80000000, 32'd2); wait_long(bc, dc); read_hilo(h, l);
    checks++; if ({h, l} !== 64'h12345676_FFFFFFFE) begin errors++; $display("FAIL msubu_result: got %h want 12345676FFFFFFFE", {h, l}); end
  endtask

  task automatic test_divzero;
    int bc, dc; logic [31:0] h, l;
    issue(MTLO, 32'hAA, 32'd0);
    issue(DIVU, 32'd5, 32'd0); wait_long(bc, dc); read_hilo(h, l);
    checks++; if (bc !== 10) begin errors++; $display("FAIL div0_busy_cycles: got %0d want 10", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL div0_done_pulses: got %0d want 1", dc); end
    checks++; if ({h, l} !== 64'h12345676_000000AA) begin errors++; $display("FAIL div0_hilo_kept: got %h want 12345676000000AA", {h, l}); end
  endtask

  task automatic test_flush;
    int dc; logic [31:0] h, l;
    issue(MTHI, 32'h11, 32'd0); issue(MTLO, 32'h22, 32'd0);
    issue(MULT, 32'd3, 32'd4);
    @(negedge clk); @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    dc = 0;
    for (int i = 0; i < 8; i++) begin if (done) dc++; @(negedge clk); end
    checks++; if (dc !== 0) begin errors++; $display("FAIL flush_no_done: got %0d want 0", dc); end
    read_hilo(h, l);
    checks++; if ({h, l} !== 64'h00000011_00000022) begin errors++; $display("FAIL flush_hilo: got %h want 0000001100000022", {h, l}); end
    issue(MULT, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) @(negedge clk);
    flush = 1;
    @(negedge clk); flush = 0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_commit_busy_done: got %b%b want 00", busy, done); end
    @(negedge clk); read_hilo(h, l);
    checks++; if ({h, l} !== 64'h00000011_00000022) begin errors++; $display("FAIL flush_commit_hilo: got %h want 0000001100000022", {h, l}); end
    @(negedge clk); start = 1; flush = 1; md_type = MTHI; rs = 32'hDEAD;
    @(negedge clk); md_type = MULT; rs = 32'd5; rt = 32'd5;
    @(negedge clk); start = 0; flush = 0; md_type = NONE;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_long_busy: got %b want 0", busy); end
    read_hilo(h, l);
    checks++; if ({h, l} !== 64'h00000011_00000022) begin errors++; $display("FAIL flush_idle_mthi: got %h want 0000001100000022", {h, l}); end
  endtask

  task automatic test_back_to_back;
    int bc; logic [31:0] h, l;
    issue(MULT, 32'd3, 32'd4);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (i > 0 && !busy && !done) break;
      start = (i == 1 || i == 2);
      md_type = (i == 1) ? MTHI : (i == 2) ? MULT : NONE;
      rs = (i == 1) ? 32'h999 : 32'd7; rt = 32'd7;
      @(negedge clk);
    end
    start = 0; md_type = NONE;
    checks++; if (bc !== 5) begin errors++; $display("FAIL busy_ignore_cycles: got %0d want 5", bc); end
    read_hilo(h, l);
    checks++; if ({h, l} !== 64'h00000000_0000000C) begin errors++; $display("FAIL busy_ignore_result: got %h want 000000000000000C", {h, l}); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] h, l;
    issue(MTLO, 32'h55, 32'd0);
    issue(DIVU, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 reset = 0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_reset_busy_done: got %b%b want 00", busy, done); end
    md_type = MFLO; #0.5;
    checks++; if (md_out !== 32'h0) begin errors++; $display("FAIL async_reset_lo: got %h want 0", md_out); end
    md_type = NONE;
    @(negedge clk); reset = 1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    read_hilo(h, l);
    checks++; if ({h, l} !== 64'h0 || busy !== 1'b0) begin errors++; $display("FAIL reset_op_lost: got %h busy %b want 0 busy 0", {h, l}, busy); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_macc();
    test_divzero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the 5-stage pipeline; sits in E stage beside the ALU.
- Generalises the fixed MDU in three ways:
  - configurable data width and configurable multiply/divide latencies;
  - multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU);
  - a flush input so an exception/interrupt can cancel an in-flight op without corrupting HI/LO.
- busy feeds the stall controller; md_out is muxed into the E→M pipeline register.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥8, even).
- MUL_CYCLES, 5, busy cycles for the multiply class (≥1).
- DIV_CYCLES, 10, busy cycles for the divide class (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  issue strobe for the op on md_type; qualified by !busy && !flush.
- md_type  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 13–15 treated as NONE.
- rs  in  WIDTH  operand A (forwarded value).
- rt  in  WIDTH  operand B (forwarded value).
- flush  in  1  cancel in-flight op and ignore start this cycle.
- busy  out  1  long op in progress.
- done  out  1  one-cycle pulse: HI/LO committed by a long op.
- md_out  out  WIDTH  HI for MFHI, LO for MFLO, else 0 (combinational on md_type).

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, done=0, counter=0, state IDLE. md_out follows md_type (0 for NONE).
- States: IDLE, RUN.
- Accept condition: start && !busy && !flush at a rising edge.
- IDLE, accept with MTHI/MTLO:
  - hi (or lo) ← rs at that edge.
  - busy stays 0; no done.
- IDLE, accept with a long op:
  - Long ops are MULT, MULTU, DIV, DIVU and the MADD/MSUB family.
  - At that edge, latch the result of that op (computed from rs/rt as sampled at the edge) plus any accumulate base into internal pending_hi/pending_lo.
  - Load counter with MUL_CYCLES (mult class) or DIV_CYCLES (div class); go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each edge.
  - At the edge where counter==1: hi←pending_hi, lo←pending_lo, busy→0, done=1 for the following cycle, state IDLE.
  - Net effect: busy high exactly N cycles; an MFHI in the first cycle after busy falls sees the new value.
- start while busy: ignored. The stall controller must hold MD instructions in D; the bench checks no state change.
- MFHI/MFLO:
  - Never need start and never alter state.
  - md_out during busy reflects the old HI/LO; a legal pipeline never reads it.
- Multiply:
  - MULT signed, MULTU unsigned, full 2·WIDTH product; {hi,lo}=product.
- MADD/MADDU/MSUB/MSUBU:
  - {hi,lo} ← {hi,lo} ± product, mod 2^(2·WIDTH), with signedness per op.
  - The base is the hi/lo value at the accepting edge.
- Divide:
  - lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed overflow (most-negative / −1): lo=most-negative, hi=0.
  - Divide by zero: the op still runs DIV_CYCLES busy cycles, but hi/lo are left unchanged and done still pulses.
- flush:
  - In RUN: at the next edge return to IDLE, busy=0, pending result discarded, hi/lo unchanged, no done.
  - In IDLE: start is ignored, including MTHI/MTLO.
  - flush on the commit edge (counter==1) wins: no commit.
- Reset mid-operation: everything returns to reset values immediately and the op is lost.
- Widths: all HI/LO arithmetic is exactly WIDTH bits per register; no X propagation from unused md_type codes.

Test Plan:
- MULT, rs=0xFFFFFFFE (−2), rt=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once; MFHI then returns 0xFFFFFFFF.
- DIVU rs=100, rt=7 → busy 10 cycles; then lo=14, hi=2. DIV rs=−7 (0xFFFFFFF9), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678, MTLO 1 (consecutive cycles, no busy); then MADDU rs=2, rt=3 → hi=0x12345678, lo=7; then MSUB rs=1, rt=8 → lo=0xFFFFFFFF, hi=0x12345677.
- DIVU rt=0 after MTLO 0xAA → busy 10 cycles; lo stays 0xAA, hi unchanged, done pulses.
- MULT, then flush asserted in busy cycle 3 → busy low next cycle, hi/lo keep prior values, no done. Also flush exactly on the commit cycle → no commit. Also start+flush in IDLE with MTHI → hi unchanged.
- Pull reset low mid-DIV (cycle 4) → busy, hi, lo, done go to 0 asynchronously; after release, MFLO returns 0. A start pulsed while busy is ignored (hi/lo match the single-op result).
